countdown_timer: RTL and testbench



---
 rtl/countdown_timer.sv | 98 +++++++++
 tb/tb_countdown_timer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Two-digit loadable down-counter with start/pause control and an expiry pulse.
// Optional periodic mode when COUNTDOWN_AUTO_RELOAD_EN is defined: expiry reloads the last loaded value.
module countdown_timer #(
  parameter int WIDTH     = 7,
  parameter int MAX_VALUE = 99
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             done,
  output logic             zero
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VALUE);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

  state_t           state, state_n;
  logic [WIDTH-1:0] count_n;
  logic [WIDTH-1:0] clamped;
  logic             done_n;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_reg, reload_n;
`endif

  assign clamped = (load_value > MAX_W) ? MAX_W : load_value;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      count   <= '0;
      running <= 1'b0;
      done    <= 1'b0;
      zero    <= 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_reg <= '0;
`endif
    end else begin
      state   <= state_n;
      count   <= count_n;
      running <= (state_n == RUN);
      done    <= done_n;
      zero    <= (count_n == '0);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_reg <= reload_n;
`endif
    end
  end

  // Commands that do not apply in the current state fall through to the next lower priority one.
  always_comb begin
    state_n = state;
    count_n = count;
    done_n  = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    reload_n = reload_reg;
`endif
    if (load) begin
      count_n = clamped;
      state_n = IDLE;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_n = clamped;
`endif
    end else if (start && (state == IDLE || state == DONE) && count != '0) begin
      state_n = RUN;
    end else if (pause && state == RUN) begin
      state_n = PAUSE;
    end else if (pause && state == PAUSE) begin
      state_n = RUN;
    end else if (en && state == RUN) begin
      if (count > ONE_W) begin
        count_n = count - ONE_W;
      end else if (count == ONE_W) begin
        done_n = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        if (reload_reg != '0) begin
          count_n = reload_reg;
        end else begin
          count_n = '0;
          state_n = DONE;
        end
`else
        count_n = '0;
        state_n = DONE;
`endif
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer; define COUNTDOWN_AUTO_RELOAD_EN to cover periodic mode.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [6:0] load_value = '0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [6:0] count;
  logic       running;
  logic       done;
  logic       zero;

  int checks = 0;
  int errors = 0;

  countdown_timer #(.WIDTH(7), .MAX_VALUE(99)) dut (
    .clk(clk), .rstn(rstn), .en(en), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .count(count), .running(running),
    .done(done), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic l, input logic [6:0] lv, input logic s,
                               input logic p, input logic e);
    load = l; load_value = lv; start = s; pause = p; en = e;
    step();
    load = 1'b0; start = 1'b0; pause = 1'b0; en = 1'b0;
  endtask

  task automatic tickGap();
    applyStimulus(1'b0, 7'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int exp_t1 [5] = '{4, 3, 2, 1, 0};
    int exp_t6 [7] = '{2, 1, 3, 2, 1, 3, 2};
    int dn_t6  [7] = '{0, 0, 1, 0, 0, 1, 0};

    // Test 1: reset values, then a full countdown from 5
    idle(2);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_running", running, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_zero", zero, 1);
    rstn = 1'b1;
    applyStimulus(1'b1, 7'd5, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_load_count", count, 5);
    checkOutput("t1_load_zero", zero, 0);
    applyStimulus(1'b0, 7'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("t1_start_running", running, 1);
    for (int i = 0; i < 5; i++) begin
      idle(9);
      tickGap();
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      checkOutput("t1_tick_count", count, (i == 4) ? 5 : exp_t1[i]);
`else
      checkOutput("t1_tick_count", count, exp_t1[i]);
`endif
      checkOutput("t1_tick_done", done, (i == 4) ? 1 : 0);
    end
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    checkOutput("t1_end_running", running, 1);
    checkOutput("t1_end_zero", zero, 0);
`else
    checkOutput("t1_end_running", running, 0);
    checkOutput("t1_end_zero", zero, 1);
`endif
    step();
    checkOutput("t1_done_one_clk", done, 0);
`ifndef COUNTDOWN_AUTO_RELOAD_EN
    tickGap();
    checkOutput("t1_no_underflow", count, 0);
    checkOutput("t1_no_second_done", done, 0);
`endif

    // Test 2: clamp and ticks ignored before start
    applyStimulus(1'b1, 7'd120, 1'b0, 1'b0, 1'b0);
    checkOutput("t2_clamp", count, 99);
    tickGap(); tickGap(); tickGap();
    checkOutput("t2_idle_ticks", count, 99);
    checkOutput("t2_running", running, 0);

    // Test 3: pause freezes count, second pause resumes
    applyStimulus(1'b1, 7'd10, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 7'd0, 1'b1, 1'b0, 1'b0);
    tickGap(); idle(2); tickGap(); idle(2); tickGap();
    checkOutput("t3_after3", count, 7);
    applyStimulus(1'b0, 7'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("t3_paused_running", running, 0);
    for (int i = 0; i < 4; i++) tickGap();
    checkOutput("t3_frozen", count, 7);
    applyStimulus(1'b0, 7'd0, 1'b0, 1'b1, 1'b0);
    tickGap(); tickGap();
    checkOutput("t3_resumed_count", count, 5);
    checkOutput("t3_resumed_running", running, 1);

    // Test 4: load beats a simultaneous tick while running
    applyStimulus(1'b1, 7'd3, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 7'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 7'd40, 1'b0, 1'b0, 1'b1);
    checkOutput("t4_count", count, 40);
    checkOutput("t4_running", running, 0);
    checkOutput("t4_done", done, 0);
    checkOutput("t4_zero", zero, 0);

    // Test 5: start with zero ignored; reset mid-run
    applyStimulus(1'b1, 7'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 7'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("t5_zero_start_running", running, 0);
    checkOutput("t5_zero_start_zero", zero, 1);
    applyStimulus(1'b1, 7'd4, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 7'd0, 1'b1, 1'b0, 1'b0);
    tickGap(); tickGap();
    checkOutput("t5_prereset_count", count, 2);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    checkOutput("t5_rst_count", count, 0);
    checkOutput("t5_rst_running", running, 0);
    checkOutput("t5_rst_done", done, 0);
    checkOutput("t5_rst_zero", zero, 1);

    // Simultaneous start/pause: start wins in IDLE, pause wins in RUN
    applyStimulus(1'b1, 7'd6, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 7'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("sp_idle_running", running, 1);
    applyStimulus(1'b0, 7'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("sp_run_paused", running, 0);
    tickGap();
    checkOutput("sp_run_frozen", count, 6);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    // Test 6: periodic reload
    applyStimulus(1'b1, 7'd3, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 7'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tickGap();
      checkOutput("t6_count", count, exp_t6[i]);
      checkOutput("t6_done", done, dn_t6[i]);
      checkOutput("t6_running", running, 1);
      checkOutput("t6_zero", zero, 0);
      step();
      checkOutput("t6_done_low", done, 0);
    end
`else
    if (exp_t6[0] != dn_t6[0]) idle(1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
